mem_ctrl_mb: RTL

Parameterised, cycle-accurate main-memory model for the cache lab. It sits on the cache-to-memory C2 bus, behind the cache. It moves whole cache lines as multi-beat transfers over a narrow data bus, with a programmable access latency. Unlike the single-cycle predecessor, it has split in/out buses, real write capture, a busy/latency FSM and protocol-error detection.

---
 rtl/mem_pkg.sv | 24 ++
 rtl/mem_lat_counter.sv | 38 +++
 rtl/mem_ctrl_mb.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared C2 bus encodings, FSM states and default sizes for the mem_ctrl_mb main-memory model.
package mem_pkg;

  typedef enum logic [1:0] {
    C2_NOP      = 2'd0,
    C2_RESPONSE = 2'd1,
    C2_READ     = 2'd2,
    C2_WRITE    = 2'd3
  } c2_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_CAP,
    ST_LAT,
    ST_RD_RESP,
    ST_WR_RESP
  } mem_state_e;

  localparam int DEF_ADDR_SIZE   = 19;
  localparam int DEF_OFFSET_SIZE = 4;
  localparam int DEF_BUS_SIZE    = 16;
  localparam int DEF_MEM_LATENCY = 100;

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter with zero flag; shared by latency and beat counting in mem_ctrl_mb.
module mem_lat_counter #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // NOTE: state flops use non-blocking assignment so all of them see pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_ctrl_mb.sv
// Multi-beat C2 main-memory model with programmable latency and write-burst abort detection.
// Optional MEM_PATTERN_INIT_EN: each reset fills storage with the 00/FF byte pattern.
module mem_ctrl_mb
  import mem_pkg::*;
#(
  parameter int ADDR_SIZE   = DEF_ADDR_SIZE,
  parameter int OFFSET_SIZE = DEF_OFFSET_SIZE,
  parameter int BUS_SIZE    = DEF_BUS_SIZE,
  parameter int MEM_LATENCY = DEF_MEM_LATENCY
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [ADDR_SIZE-OFFSET_SIZE-1:0] addr,
  input  logic [1:0]                      cmd_in,
  input  logic [BUS_SIZE-1:0]             data_in,
  output logic [1:0]                      cmd_out,
  output logic [BUS_SIZE-1:0]             data_out,
  output logic                            busy,
  output logic                            proto_err
);

  localparam int LINE_BITS = 8 << OFFSET_SIZE;
  localparam int BEATS     = LINE_BITS / BUS_SIZE;
  localparam int LA_W      = ADDR_SIZE - OFFSET_SIZE;
  localparam int LINES     = 2 ** LA_W;
  localparam int CNT_W     = $clog2(MEM_LATENCY + BEATS);

  // Latency phase lasts MEM_LATENCY-1 cycles, so the counter starts one below that.
  localparam logic [CNT_W-1:0] LAT_LOAD  = CNT_W'(MEM_LATENCY - 2);
  localparam logic [CNT_W-1:0] BEAT_LOAD = CNT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0] CAP_LOAD  = CNT_W'(BEATS - 2);

  function automatic logic [BUS_SIZE-1:0] beat_of(input logic [LINE_BITS-1:0] line, input int idx);
    return line[idx*BUS_SIZE +: BUS_SIZE];
  endfunction

  mem_state_e              state_q, state_d;
  c2_cmd_e                 cmd_out_q, cmd_out_d;
  logic [BUS_SIZE-1:0]     data_out_q, data_out_d;
  logic                    busy_q, busy_d;
  logic                    perr_q, perr_d;
  logic [LA_W-1:0]         addr_q, addr_d;
  logic [LINE_BITS-1:0]    wr_line_q, wr_line_d;
  logic                    is_wr_q, is_wr_d;

  logic                    cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0]        cnt_load_val, cnt;
  logic                    commit;
  logic [LA_W-1:0]         commit_addr;
  logic [LINE_BITS-1:0]    rd_line;

  logic [LINE_BITS-1:0]    mem_q [LINES];

  mem_lat_counter #(.W(CNT_W)) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .cnt_o      (cnt),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wr_line_d    = wr_line_q;
    is_wr_d      = is_wr_q;
    data_out_d   = '0;
    perr_d       = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    commit       = 1'b0;
    commit_addr  = addr_q;
    rd_line      = mem_q[(state_q == ST_IDLE) ? addr : addr_q];

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_in == C2_READ) begin
          addr_d  = addr;
          is_wr_d = 1'b0;
          if (MEM_LATENCY == 1) begin
            state_d      = ST_RD_RESP;
            cnt_load     = 1'b1;
            cnt_load_val = BEAT_LOAD;
            data_out_d   = beat_of(rd_line, 0);
          end else begin
            state_d      = ST_LAT;
            cnt_load     = 1'b1;
            cnt_load_val = LAT_LOAD;
          end
        end else if (cmd_in == C2_WRITE) begin
          addr_d                  = addr;
          is_wr_d                 = 1'b1;
          wr_line_d[0 +: BUS_SIZE] = data_in;
          if (BEATS == 1) begin
            commit      = 1'b1;
            commit_addr = addr;
            if (MEM_LATENCY == 1) begin
              state_d = ST_WR_RESP;
            end else begin
              state_d      = ST_LAT;
              cnt_load     = 1'b1;
              cnt_load_val = LAT_LOAD;
            end
          end else begin
            state_d      = ST_WR_CAP;
            cnt_load     = 1'b1;
            cnt_load_val = CAP_LOAD;
          end
        end
      end

      ST_WR_CAP: begin
        if (cmd_in != C2_WRITE) begin
          perr_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wr_line_d[(BEATS - 1 - int'(cnt))*BUS_SIZE +: BUS_SIZE] = data_in;
          if (cnt_zero) begin
            commit = 1'b1;
            if (MEM_LATENCY == 1) begin
              state_d = ST_WR_RESP;
            end else begin
              state_d      = ST_LAT;
              cnt_load     = 1'b1;
              cnt_load_val = LAT_LOAD;
            end
          end else begin
            cnt_dec = 1'b1;
          end
        end
      end

      ST_LAT: begin
        if (cnt_zero) begin
          if (is_wr_q) begin
            state_d = ST_WR_RESP;
          end else begin
            state_d      = ST_RD_RESP;
            cnt_load     = 1'b1;
            cnt_load_val = BEAT_LOAD;
            data_out_d   = beat_of(rd_line, 0);
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end

      ST_RD_RESP: begin
        // The counter holds beats still to come, so the next beat index is BEATS-cnt.
        if (cnt_zero) begin
          state_d = ST_IDLE;
        end else begin
          cnt_dec    = 1'b1;
          data_out_d = beat_of(rd_line, BEATS - int'(cnt));
        end
      end

      ST_WR_RESP: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    cmd_out_d = ((state_d == ST_RD_RESP) || (state_d == ST_WR_RESP)) ? C2_RESPONSE : C2_NOP;
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cmd_out_q  <= C2_NOP;
      data_out_q <= '0;
      busy_q     <= 1'b0;
      perr_q     <= 1'b0;
      addr_q     <= '0;
      wr_line_q  <= '0;
      is_wr_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_out_q  <= cmd_out_d;
      data_out_q <= data_out_d;
      busy_q     <= busy_d;
      perr_q     <= perr_d;
      addr_q     <= addr_d;
      wr_line_q  <= wr_line_d;
      is_wr_q    <= is_wr_d;
    end
  end

`ifdef MEM_PATTERN_INIT_EN
  function automatic logic [LINE_BITS-1:0] pattern_line();
    logic [LINE_BITS-1:0] l;
    l = '0;
    for (int i = 0; i < LINE_BITS/8; i++) begin
      l[i*8 +: 8] = (i % 2 == 1) ? 8'hFF : 8'h00;
    end
    return l;
  endfunction

  localparam logic [LINE_BITS-1:0] PATTERN_LINE = pattern_line();

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < LINES; i++) begin
        mem_q[i] <= PATTERN_LINE;
      end
    end else if (commit) begin
      mem_q[commit_addr] <= wr_line_d;
    end
  end
`else
  // NOTE: storage has no reset path; reset only clears control flops and blocks a pending commit.
  always_ff @(posedge clk) begin
    if (reset && commit) begin
      mem_q[commit_addr] <= wr_line_d;
    end
  end
`endif

  assign cmd_out   = cmd_out_q;
  assign data_out  = data_out_q;
  assign busy      = busy_q;
  assign proto_err = perr_q;

endmodule
